usb_pattern_gen: RTL

//  Parametrised multi-mode test-data source for the USB interface datapath.

---
 rtl/usb_tp_pkg.sv | 25 ++
 rtl/usb_pattern_gen_if.sv | 12 +
 rtl/usb_pattern_core.sv | 81 ++++++++
 rtl/usb_pattern_gen.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/usb_tp_pkg.sv
// Shared encodings for the USB test-pattern generator: pattern modes, FSM
// states and the PRBS feedback polynomial.
package usb_tp_pkg;

  typedef enum logic [1:0] {
    MODE_CNT  = 2'd0,
    MODE_WALK = 2'd1,
    MODE_PRBS = 2'd2,
    MODE_ALT  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_e;

  // Right-shift Galois form of x^31+x^28+1: feedback lands on bits 30 and 27.
  localparam logic [31:0] LFSR_TAP = 32'h4800_0000;

  function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
    lfsr_step = {1'b0, cur[31:1]} ^ (cur[0] ? LFSR_TAP : 32'h0000_0000);
  endfunction

endpackage

// File: rtl/usb_pattern_gen_if.sv
// Write-side handshake between the pattern generator and the USB TX FIFO.
interface usb_pattern_gen_if #(
  parameter int DATA_W = 32
);
  logic              fifo_wr;
  logic [DATA_W-1:0] data;
  logic              fifo_full;
  logic              fifo_almst_full;

  modport master (output fifo_wr, output data, input fifo_full, input fifo_almst_full);
  modport slave  (input fifo_wr, input data, output fifo_full, output fifo_almst_full);
endinterface

// File: rtl/usb_pattern_core.sv
// Pattern state for all four modes; only the selected mode's state steps on
// adv_i, so switching modes resumes each sequence where it stopped.
module usb_pattern_core
  import usb_tp_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter logic [31:0] LFSR_SEED = 32'h0000_0001
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  mode_e             mode_i,
  input  logic [DATA_W-1:0] wrap_i,
  input  logic              adv_i,
  output logic [DATA_W-1:0] value_o
);

  localparam logic [DATA_W-1:0] ONE   = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] ZERO  = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] ALT_A = {(DATA_W/2){2'b10}};
  localparam logic [DATA_W-1:0] ALT_5 = {(DATA_W/2){2'b01}};

  logic [DATA_W-1:0] cnt_q, cnt_d, walk_q, walk_d, prbs_s;
  logic [31:0]       lfsr_q, lfsr_d;
  logic              alt_q, alt_d;

  if (DATA_W > 32) begin : g_prbs_wide
    assign prbs_s = {{(DATA_W-32){1'b0}}, lfsr_q};
  end else if (DATA_W == 32) begin : g_prbs_full
    assign prbs_s = lfsr_q;
  end else begin : g_prbs_narrow
    logic prbs_unused_s;
    assign prbs_s        = lfsr_q[DATA_W-1:0];
    assign prbs_unused_s = ^lfsr_q[31:DATA_W];
  end

  // next-state of the pattern registers
  always_comb begin
    cnt_d  = cnt_q;
    walk_d = walk_q;
    lfsr_d = lfsr_q;
    alt_d  = alt_q;
    if (adv_i) begin
      case (mode_i)
        MODE_CNT:  cnt_d  = (cnt_q >= wrap_i) ? ZERO : cnt_q + ONE;
        MODE_WALK: walk_d = {walk_q[DATA_W-2:0], walk_q[DATA_W-1]};
        MODE_PRBS: lfsr_d = lfsr_step(lfsr_q);
        MODE_ALT:  alt_d  = ~alt_q;
        default:   cnt_d  = cnt_q;
      endcase
    end else begin
      cnt_d = cnt_q;
    end
  end

  // current pattern value for the selected mode
  always_comb begin
    case (mode_i)
      MODE_CNT:  value_o = cnt_q;
      MODE_WALK: value_o = walk_q;
      MODE_PRBS: value_o = prbs_s;
      MODE_ALT:  value_o = alt_q ? ALT_5 : ALT_A;
      default:   value_o = cnt_q;
    endcase
  end

  // pattern registers; restart only on reset
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q  <= ZERO;
      walk_q <= ONE;
      lfsr_q <= LFSR_SEED;
      alt_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      walk_q <= walk_d;
      lfsr_q <= lfsr_d;
      alt_q  <= alt_d;
    end
  end

endmodule

// File: rtl/usb_pattern_gen.sv
// Multi-mode test-data source for the USB TX FIFO: burst/gap sequencing,
// flag-throttled registered write strobe and word/overflow status.
module usb_pattern_gen
  import usb_tp_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          BLEN_W    = 16,
  parameter int          GAP_W     = 8,
  parameter logic [31:0] LFSR_SEED = 32'h0000_0001
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              en_i,
  input  logic [1:0]        mode_i,
  input  logic [DATA_W-1:0] wrap_i,
  input  logic [BLEN_W-1:0] burst_len_i,
  input  logic [GAP_W-1:0]  gap_i,
  usb_pattern_gen_if.master fifo_if,
  output logic              burst_done_o,
  output logic [31:0]       word_cnt_o,
  output logic              busy_o,
  output logic              ovf_o
);

  localparam logic [BLEN_W-1:0] BLEN_ONE  = {{(BLEN_W-1){1'b0}}, 1'b1};
  localparam logic [BLEN_W-1:0] BLEN_ZERO = {BLEN_W{1'b0}};
  localparam logic [GAP_W-1:0]  GAP_ONE   = {{(GAP_W-1){1'b0}}, 1'b1};
  localparam logic [GAP_W-1:0]  GAP_ZERO  = {GAP_W{1'b0}};

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [DATA_W-1:0] wrap_q, wrap_d, data_q, data_d, pat_s;
  logic [BLEN_W-1:0] blen_q, blen_d, bcnt_q, bcnt_d, bcnt_inc_s;
  logic [GAP_W-1:0]  gap_q, gap_d, gcnt_q, gcnt_d, gcnt_inc_s;
  logic              wr_q, wr_d, done_q, done_d, busy_q, busy_d, ovf_q, ovf_d;
  logic              adv_s, req_ok_s;
  logic [31:0]       word_cnt_q, word_cnt_d;

  usb_pattern_core #(
    .DATA_W   (DATA_W),
    .LFSR_SEED(LFSR_SEED)
  ) u_core (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .mode_i (mode_q),
    .wrap_i (wrap_q),
    .adv_i  (adv_s),
    .value_o(pat_s)
  );

  assign req_ok_s   = ~fifo_if.fifo_almst_full & ~fifo_if.fifo_full;
  assign bcnt_inc_s = bcnt_q + BLEN_ONE;
  assign gcnt_inc_s = gcnt_q + GAP_ONE;

  // FSM next-state, burst/gap counting and write request
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    wrap_d  = wrap_q;
    blen_d  = blen_q;
    gap_d   = gap_q;
    bcnt_d  = bcnt_q;
    gcnt_d  = gcnt_q;
    wr_d    = 1'b0;
    done_d  = 1'b0;
    adv_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_i) begin
          state_d = RUN;
          mode_d  = mode_e'(mode_i);
          wrap_d  = wrap_i;
          blen_d  = burst_len_i;
          gap_d   = gap_i;
          bcnt_d  = BLEN_ZERO;
          gcnt_d  = GAP_ZERO;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (!en_i) begin
          state_d = IDLE;
          bcnt_d  = BLEN_ZERO;
        end else if (req_ok_s) begin
          wr_d  = 1'b1;
          adv_s = 1'b1;
          // a zero burst length means continuous streaming
          if ((blen_q != BLEN_ZERO) && (bcnt_inc_s == blen_q)) begin
            done_d = 1'b1;
            bcnt_d = BLEN_ZERO;
            gcnt_d = GAP_ZERO;
            state_d = (gap_q != GAP_ZERO) ? GAP : RUN;
          end else begin
            bcnt_d = bcnt_inc_s;
          end
        end else begin
          state_d = RUN;
        end
      end
      GAP: begin
        if (!en_i) begin
          state_d = IDLE;
          gcnt_d  = GAP_ZERO;
        end else if (gcnt_inc_s == gap_q) begin
          state_d = RUN;
          gcnt_d  = GAP_ZERO;
        end else begin
          gcnt_d = gcnt_inc_s;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // output-side next values
  always_comb begin
    data_d     = adv_s ? pat_s : data_q;
    busy_d     = (state_d != IDLE);
    ovf_d      = ovf_q | (wr_q & fifo_if.fifo_full);
    word_cnt_d = word_cnt_q + {31'd0, wr_q};
  end

  // state and output registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      mode_q     <= MODE_CNT;
      wrap_q     <= {DATA_W{1'b0}};
      blen_q     <= BLEN_ZERO;
      gap_q      <= GAP_ZERO;
      bcnt_q     <= BLEN_ZERO;
      gcnt_q     <= GAP_ZERO;
      wr_q       <= 1'b0;
      data_q     <= {DATA_W{1'b0}};
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      word_cnt_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      wrap_q     <= wrap_d;
      blen_q     <= blen_d;
      gap_q      <= gap_d;
      bcnt_q     <= bcnt_d;
      gcnt_q     <= gcnt_d;
      wr_q       <= wr_d;
      data_q     <= data_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign fifo_if.fifo_wr = wr_q;
  assign fifo_if.data    = data_q;
  assign burst_done_o    = done_q;
  assign busy_o          = busy_q;
  assign ovf_o           = ovf_q;
  assign word_cnt_o      = word_cnt_q;

endmodule
